// File: rtl/typedefs.sv
// Shared types for the Genius game datapath.
package typedefs;
  typedef enum logic [1:0] {
    COLOR_RED    = 2'd0,
    COLOR_GREEN  = 2'd1,
    COLOR_BLUE   = 2'd2,
    COLOR_YELLOW = 2'd3
  } color_t;
endpackage

// File: rtl/genius_sequence_player.sv
// Stores the Genius color sequence and plays it back to the LED driver:
// each color lit for ON_CYCLES, then dark for OFF_CYCLES, with a start/done handshake.
module genius_sequence_player
  import typedefs::*;
#(
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         append_valid,
  input  color_t                       append_color,
  input  logic                         clear,
  input  logic                         start,
  output logic [$clog2(MAX_LEN+1)-1:0] seq_len,
  output logic                         full,
  output logic                         busy,
  output logic                         done,
  output logic                         led_enable,
  output color_t                       led_color
);

  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [LEN_W-1:0] r_seq_len;
  color_t           r_color;
  color_t           r_buf [0:MAX_LEN-1];

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [LEN_W-1:0] w_len_next;
  logic             w_wr_en;
  logic             w_load_color;
  logic [IDX_W-1:0] w_rd_addr;
  logic             w_full;
  logic             w_last;

  assign w_full = (r_seq_len == LEN_MAX);
  assign w_last = (LEN_W'(r_idx) == (r_seq_len - LEN_W'(1)));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_len_next   = r_seq_len;
    w_wr_en      = 1'b0;
    w_load_color = 1'b0;
    w_rd_addr    = '0;
    case (r_state)
      IDLE: begin
        // clear beats start, start beats append
        if (clear) begin
          w_len_next = '0;
        end else if (start) begin
          if (r_seq_len != '0) begin
            w_idx_next   = '0;
            w_cnt_next   = ON_LOAD;
            w_load_color = 1'b1;
            w_rd_addr    = '0;
            w_state_next = ON;
          end else begin
            w_state_next = DONE;
          end
        end else if (append_valid && !w_full) begin
          w_wr_en    = 1'b1;
          w_len_next = r_seq_len + LEN_W'(1);
        end
      end
      ON: begin
        if (clear) begin
          w_len_next   = '0;
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else if (r_cnt == '0) begin
          w_cnt_next   = OFF_LOAD;
          w_state_next = OFF;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      OFF: begin
        if (clear) begin
          w_len_next   = '0;
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else if (r_cnt == '0) begin
          if (w_last) begin
            w_state_next = DONE;
          end else begin
            w_idx_next   = r_idx + IDX_W'(1);
            w_rd_addr    = r_idx + IDX_W'(1);
            w_load_color = 1'b1;
            w_cnt_next   = ON_LOAD;
            w_state_next = ON;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        if (clear) begin
          w_len_next = '0;
        end
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_seq_len <= '0;
      r_color   <= COLOR_RED;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_seq_len <= w_len_next;
      if (w_load_color) begin
        r_color <= r_buf[w_rd_addr];
      end
    end
  end

  // Buffer contents survive rst and clear; only seq_len bounds what is played.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      r_buf[r_seq_len[IDX_W-1:0]] <= append_color;
    end
  end

  assign seq_len    = r_seq_len;
  assign full       = w_full;
  assign busy       = (r_state == ON) || (r_state == OFF);
  assign done       = (r_state == DONE);
  assign led_enable = (r_state == ON);
  assign led_color  = r_color;

endmodule

// File: doc/genius_sequence_player.md
# genius_sequence_player

Playback controller for the Genius game LED stage. It holds the game's color sequence in an internal buffer and steps through it, driving the enable and color inputs of the LED driver. Each color is shown for a fixed on-time, followed by a fixed dark gap. Game logic appends one color per round, then requests playback with a start/done handshake. The block sits between the game FSM and the LED driver.

## Interface
- MAX_LEN, default 32: sequence buffer depth in entries; must be ≥1.
- ON_CYCLES, default 25_000_000: clock cycles each color is lit; must be ≥1.
- OFF_CYCLES, default 12_500_000: dark clock cycles after each color; must be ≥1.
- clk  in  1  system clock; one clock domain, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- append_valid  in  1  write append_color at index seq_len (single-cycle strobe).
- append_color  in  color_t  color to append (typedefs::color_t, 2 bits).
- clear  in  1  empty the sequence; aborts playback.
- start  in  1  request playback of the whole sequence (single-cycle strobe).
- seq_len  out  $clog2(MAX_LEN+1)  number of stored entries.
- full  out  1  seq_len == MAX_LEN.
- busy  out  1  playback in progress.
- done  out  1  one-cycle pulse when playback completes normally.
- led_enable  out  1  drives the LED driver enable input.
- led_color  out  color_t  drives the LED driver color input.

## Operation
- State machine states: IDLE, ON, OFF, DONE. A down-counter is sized for max(ON_CYCLES, OFF_CYCLES). A play index is $clog2(MAX_LEN) bits.
- IDLE behavior:
  - clear has top priority: seq_len goes to 0, and start and append are ignored.
  - start with seq_len > 0: idx is set to 0, led_color loads buf[0], and the FSM moves to ON.
  - start with seq_len == 0: the FSM moves directly to DONE.
  - start has priority over append_valid in the same cycle; that append is dropped.
  - append_valid with full == 0: buf[seq_len] is written and seq_len increments. When full == 1, the append is dropped silently.
- ON state: led_enable = 1 for exactly ON_CYCLES cycles, then the FSM moves to OFF.
- OFF state: led_enable = 0 for exactly OFF_CYCLES cycles. led_color holds its value. Then:
  - if idx == seq_len-1, the FSM moves to DONE;
  - otherwise idx increments, led_color loads buf[idx+1], and the FSM moves to ON.
- DONE state: done = 1 and busy = 0 for one cycle, then the FSM moves to IDLE.
- busy = 1 exactly in ON and OFF.
- During ON and OFF:
  - start and append_valid are ignored.
  - clear moves the FSM to IDLE on the next cycle with led_enable = 0, sets seq_len to 0, and produces no done pulse.
- Buffer contents are not erased by clear or rst; only seq_len is reset. Entries past seq_len are never played.
- led_color is registered. It changes only at entry to ON, and on reset.

## Timing
- Reset values: seq_len = 0, full = 0, busy = 0, done = 0, led_enable = 0, led_color = COLOR_RED, state = IDLE, counter = 0, idx = 0.
- rst asserted mid-playback: all of the values above apply the following cycle, and no done pulse is produced.
- start sampled high at edge k with seq_len = L > 0:
  - element i is lit during cycles k+1+i·(ON_CYCLES+OFF_CYCLES) through k+i·(ON_CYCLES+OFF_CYCLES)+ON_CYCLES;
  - done is high in cycle k+1+L·(ON_CYCLES+OFF_CYCLES).
- start with L = 0: done is high in cycle k+1, and led_enable never rises.
- Append latency: seq_len and full update in the cycle after the append_valid edge.
- A new start is accepted in the cycle after done, i.e. in IDLE.

## Test plan
Use MAX_LEN=4, ON_CYCLES=3, OFF_CYCLES=2.
- Reset check: assert rst for 2 cycles → seq_len=0, full=0, busy=0, done=0, led_enable=0, led_color=COLOR_RED.
- Basic playback: append RED, GREEN, BLUE, then start at cycle 0. Required response:
  - led_enable=1 with RED in cycles 1–3, GREEN in 6–8, BLUE in 11–13;
  - led_enable=0 in cycles 4–5, 9–10, 14–15;
  - busy=1 in cycles 1–15, done=1 only in cycle 16.
- Full boundary: append 5 colors back-to-back → seq_len goes 1, 2, 3, 4; full=1 after the 4th append; the 5th append is dropped. Playback then shows exactly 4 colors, with done at cycle 1+4·5=21.
- Empty start: with seq_len=0, start at cycle 0 → done=1 at cycle 1, busy and led_enable stay 0.
- Abort: during the basic playback, assert clear at cycle 7 → led_enable=0 and busy=0 from cycle 8, seq_len=0, and done never pulses.
- Ignored inputs and priorities:
  - start or append_valid at cycle 5 during playback → no effect on timing or seq_len;
  - clear together with start in IDLE → no playback, seq_len=0;
  - start together with append in IDLE → seq_len unchanged.
